// File: rtl/mul_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_unit_pkg
//   Shared ISA constants for the HI/LO multiply/divide unit: datapath word
//   width, SPECIAL funct field width and the funct codes the unit decodes.
//   Also holds a small helper that folds a signed operand to its magnitude.
// ---------------------------------------------------------------------------
package mul_div_unit_pkg;

    localparam int WORD = 32;
    localparam int FUN  = 6;

    // SPECIAL-opcode funct codes handled by the HI/LO unit
    localparam logic [FUN-1:0] FUN_MTHI  = 6'h11;
    localparam logic [FUN-1:0] FUN_MTLO  = 6'h13;
    localparam logic [FUN-1:0] FUN_MULT  = 6'h18;
    localparam logic [FUN-1:0] FUN_MULTU = 6'h19;
    localparam logic [FUN-1:0] FUN_DIV   = 6'h1A;
    localparam logic [FUN-1:0] FUN_DIVU  = 6'h1B;

    // Magnitude of v when treated as signed (sgn=1), raw value otherwise.
    // 32'h80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [WORD-1:0] magnitude(input logic [WORD-1:0] v,
                                                  input logic            sgn);
        return (sgn && v[WORD-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Iterative HI/LO unit: MULT/MULTU (shift-add) and DIV/DIVU (restoring
//   shift-subtract), one iteration per cycle for 32 cycles, then a sign-fix
//   cycle that writes HI/LO. MTHI/MTLO write HI/LO directly from IDLE.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request qualifier for funct/opA/opB (ignored while busy)
//   funct          SPECIAL funct code
//   opA, opB       rs / rt operand values
//   cancel         abort in-flight op (RUN/FIX); drops start in IDLE
//   busy           high whenever the unit is not IDLE
//   done           one-cycle pulse when a MULT/DIV result lands in HI/LO
//   hi, lo         architectural HI/LO registers
// ---------------------------------------------------------------------------
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [FUN-1:0]  funct,
    input  logic [WORD-1:0] opA,
    input  logic [WORD-1:0] opB,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] hi,
    output logic [WORD-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [4:0]        cnt;
    logic [2*WORD-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WORD-1:0]   opr;      // multiplicand or divisor magnitude
    logic              is_div;
    logic              neg_a;    // dividend / multiplicand-A was negative (signed ops only)
    logic              neg_b;
    logic              div0;

    // request decode
    logic is_mul_op, is_div_op, is_signed_op, is_arith, accept;
    logic [WORD-1:0] mag_a, mag_b;

    assign is_mul_op    = (funct == FUN_MULT) || (funct == FUN_MULTU);
    assign is_div_op    = (funct == FUN_DIV)  || (funct == FUN_DIVU);
    assign is_signed_op = (funct == FUN_MULT) || (funct == FUN_DIV);
    assign is_arith     = is_mul_op || is_div_op;
    assign accept       = (state == IDLE) && start && !cancel;
    assign mag_a        = magnitude(opA, is_signed_op);
    assign mag_b        = magnitude(opB, is_signed_op);

    // shared 33-bit adder/subtractor and next accumulator value
    logic [WORD:0]     add_a, sum;
    logic [2*WORD-1:0] acc_nxt;

    always_comb begin
        // divide looks at the remainder shifted left by one (brings in the
        // next dividend bit); multiply adds into the upper half directly
        add_a = is_div ? acc[2*WORD-1:WORD-1] : {1'b0, acc[2*WORD-1:WORD]};
        sum   = is_div ? add_a - {1'b0, opr} : add_a + {1'b0, opr};
        if (is_div) begin
            // sum[WORD] set means the trial subtraction borrowed: restore
            if (sum[WORD])
                acc_nxt = {acc[2*WORD-2:0], 1'b0};
            else
                acc_nxt = {sum[WORD-1:0], acc[WORD-2:0], 1'b1};
        end else begin
            if (acc[0])
                acc_nxt = {sum, acc[WORD-1:1]};
            else
                acc_nxt = {1'b0, acc[2*WORD-1:1]};
        end
    end

    // sign correction applied in FIX
    logic [2*WORD-1:0] prod_fix;
    logic [WORD-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        // divide by zero leaves remainder = |opA| and quotient = all ones;
        // the remainder sign fix below then restores the original opA
        quo_fix  = div0 ? '1
                 : ((neg_a ^ neg_b) ? -acc[WORD-1:0] : acc[WORD-1:0]);
        rem_fix  = neg_a ? -acc[2*WORD-1:WORD] : acc[2*WORD-1:WORD];
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_arith) state_nxt = RUN;
            RUN:  if (cancel)             state_nxt = IDLE;
                  else if (cnt == 5'd31)  state_nxt = FIX;
            FIX:                          state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // datapath and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opr    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_arith) begin
                        cnt    <= '0;
                        is_div <= is_div_op;
                        neg_a  <= is_signed_op & opA[WORD-1];
                        neg_b  <= is_signed_op & opB[WORD-1];
                        div0   <= (opB == '0);
                        acc    <= {{WORD{1'b0}}, is_div_op ? mag_a : mag_b};
                        opr    <= is_div_op ? mag_b : mag_a;
                    end else if (accept && funct == FUN_MTHI) begin
                        hi <= opA;
                    end else if (accept && funct == FUN_MTLO) begin
                        lo <= opA;
                    end
                end
                RUN: begin
                    if (!cancel) begin
                        acc <= acc_nxt;
                        cnt <= cnt + 5'd1;
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WORD-1:WORD];
                            lo <= prod_fix[WORD-1:0];
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int passes = 0;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
        .opA(opA), .opB(opB), .cancel(cancel),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {hi, lo} straight from the arithmetic definition
    function automatic logic [63:0] ref_model(input logic [5:0] f,
                                              input logic [31:0] a, b);
        longint      p;
        int          sa, sb, q, r;
        logic [31:0] qq, rr;
        case (f)
            F_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            F_MULTU: return {32'b0, a} * {32'b0, b};
            F_DIVU: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                qq = a / b; rr = a % b;
                return {rr, qq};
            end
            F_DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                sa = $signed(a); sb = $signed(b);
                q = sa / sb; r = sa % sb;
                qq = q; rr = r;
                return {rr, qq};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one arithmetic op and observe it (stimulus + observation only)
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, b,
                         output int lat, output logic [31:0] h, l,
                         output bit busy_ok, output bit pulse_ok);
        @(negedge clk);
        start = 1'b1; funct = f; opA = a; opB = b;
        @(posedge clk); #1;
        start = 1'b0;
        busy_ok = (busy === 1'b1);
        lat = 0; h = 'x; l = 'x; pulse_ok = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                if (busy !== 1'b0) busy_ok = 1'b0;
                h = hi; l = lo;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
            pulse_ok = (done === 1'b0);
        end
    endtask

    task automatic set_hilo(input logic [31:0] h, l);
        @(negedge clk);
        start = 1'b1; funct = F_MTHI; opA = h;
        @(negedge clk);
        funct = F_MTLO; opA = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, hi, lo} !== 66'h0)
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [5:0]  f  [6] = '{F_MULTU, F_MULT, F_DIV, F_DIVU, F_DIV, F_DIV};
        logic [31:0] a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] b  [6] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
        logic [31:0] eh [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'h0, 32'hFFFFFFF9};
        logic [31:0] el [6] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        int lat; logic [31:0] h, l; bit bok, pok;
        for (int i = 0; i < 6; i++) begin
            do_op(f[i], a[i], b[i], lat, h, l, bok, pok);
            checks++;
            if (lat != 33) $display("FAIL directed%0d_latency: got %0d cycles, want 33", i, lat);
            else passes++;
            checks++;
            if (!bok || !pok) $display("FAIL directed%0d_busy_done: busy_ok=%b pulse_ok=%b, want 1/1", i, bok, pok);
            else passes++;
            checks++;
            if (h !== eh[i]) $display("FAIL directed%0d_hi: got %h want %h", i, h, eh[i]);
            else passes++;
            checks++;
            if (l !== el[i]) $display("FAIL directed%0d_lo: got %h want %h", i, l, el[i]);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic [5:0] fs [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        int lat; logic [31:0] h, l, a, b; bit bok, pok; logic [5:0] f; logic [63:0] exp;
        for (int i = 0; i < 30; i++) begin
            f = fs[$urandom_range(0, 3)];
            a = rnd_op(); b = rnd_op();
            exp = ref_model(f, a, b);
            do_op(f, a, b, lat, h, l, bok, pok);
            checks++;
            if (lat != 33 || !bok || !pok)
                $display("FAIL random%0d_timing: lat=%0d busy_ok=%b pulse_ok=%b, want 33/1/1", i, lat, bok, pok);
            else passes++;
            checks++;
            if ({h, l} !== exp)
                $display("FAIL random%0d_result f=%h a=%h b=%h: got %h_%h want %h", i, f, a, b, h, l, exp);
            else passes++;
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo0;
        lo0 = lo;
        @(negedge clk);
        start = 1'b1; funct = F_MTHI; opA = 32'h12345678;
        @(posedge clk); #1;
        checks++;
        if (hi !== 32'h12345678 || lo !== lo0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b, want 12345678/%h/0/0", hi, lo, busy, done, lo0);
        else passes++;
        funct = F_MTLO; opA = 32'h9ABCDEF0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, want 12345678/9abcdef0/0/0", hi, lo, busy, done);
        else passes++;
    endtask

    task automatic test_ignored_funct();
        set_hilo(32'h0BADF00D, 32'hC0FFEE00);
        @(negedge clk);
        start = 1'b1; funct = 6'h20; opA = 32'h5; opB = 32'h7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0BADF00D || lo !== 32'hC0FFEE00)
            $display("FAIL ignored_funct: busy=%b hi=%h lo=%h, want 0/0badf00d/c0ffee00", busy, hi, lo);
        else passes++;
    endtask

    task automatic test_cancel_run();
        int lat; logic [31:0] h, l; bit bok, pok, saw_done;
        set_hilo(32'hAAAA5555, 32'h5555AAAA);
        @(negedge clk);
        start = 1'b1; funct = F_MULT; opA = 32'd1234; opB = 32'd5678;
        @(posedge clk); #1;               // E0
        start = 1'b0;
        repeat (5) @(negedge clk);        // before E5: re-assert start (MTHI, must be ignored)
        start = 1'b1; funct = F_MTHI; opA = 32'hDEADBEEF;
        repeat (5) @(negedge clk);        // before E10
        cancel = 1'b1;
        @(posedge clk); #1;               // after E10
        start = 1'b0; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hAAAA5555 || lo !== 32'h5555AAAA)
            $display("FAIL cancel_run: busy=%b done=%b hi=%h lo=%h, want 0/0/aaaa5555/5555aaaa", busy, done, hi, lo);
        else passes++;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || hi !== 32'hAAAA5555 || lo !== 32'h5555AAAA)
            $display("FAIL cancel_run_quiet: done_seen=%b hi=%h lo=%h, want 0/aaaa5555/5555aaaa", saw_done, hi, lo);
        else passes++;
        do_op(F_DIVU, 32'd1000, 32'd7, lat, h, l, bok, pok);
        checks++;
        if (lat != 33 || h !== 32'd6 || l !== 32'd142)
            $display("FAIL cancel_restart: lat=%0d hi=%h lo=%h, want 33/6/142", lat, h, l);
        else passes++;
    endtask

    task automatic test_cancel_fix();
        bit saw_done;
        set_hilo(32'h11112222, 32'h33334444);
        @(negedge clk);
        start = 1'b1; funct = F_MULTU; opA = 32'd3; opB = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (32) @(posedge clk);       // after E32: last busy cycle
        #1;
        checks++;
        if (busy !== 1'b1) $display("FAIL cancel_fix_busy: busy=%b want 1", busy);
        else passes++;
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        saw_done = (done === 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || busy !== 1'b0 || hi !== 32'h11112222 || lo !== 32'h33334444)
            $display("FAIL cancel_fix: done_seen=%b busy=%b hi=%h lo=%h, want 0/0/11112222/33334444", saw_done, busy, hi, lo);
        else passes++;
    endtask

    task automatic test_cancel_idle();
        set_hilo(32'h01020304, 32'h05060708);
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; funct = F_MTHI; opA = 32'hFFFF0000;
        @(posedge clk); #1;
        checks++;
        if (hi !== 32'h01020304 || busy !== 1'b0)
            $display("FAIL cancel_idle_mthi: hi=%h busy=%b, want 01020304/0", hi, busy);
        else passes++;
        funct = F_MULT;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL cancel_idle_mult: busy=%b done=%b, want 0/0", busy, done);
        else passes++;
        start = 1'b0; cancel = 1'b0;
    endtask

    task automatic test_back_to_back();
        int k1, k2;
        logic [31:0] h1, l1, h2, l2;
        k1 = 0; k2 = 0; h1 = 'x; l1 = 'x; h2 = 'x; l2 = 'x;
        @(negedge clk);
        start = 1'b1; funct = F_MULTU; opA = 32'd100000; opB = 32'd300000;
        @(posedge clk); #1;               // E0, start held
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin funct = F_DIV; opA = 32'hFFFFFF9C; opB = 32'd7; end  // -100 / 7
            if (k == 34) start = 1'b0;    // second op sampled at E34
            if (done === 1'b1) begin
                if (k1 == 0) begin k1 = k; h1 = hi; l1 = lo; end
                else begin k2 = k; h2 = hi; l2 = lo; break; end
            end
        end
        start = 1'b0;
        checks++;
        if (k1 != 33 || k2 != 67)
            $display("FAIL b2b_timing: done at %0d and %0d, want 33 and 67", k1, k2);
        else passes++;
        checks++;
        if ({h1, l1} !== 64'd30000000000)
            $display("FAIL b2b_first: got %h_%h want %h", h1, l1, 64'd30000000000);
        else passes++;
        checks++;
        if (h2 !== 32'hFFFFFFFE || l2 !== 32'hFFFFFFF2)
            $display("FAIL b2b_second: got %h_%h want fffffffe_fffffff2", h2, l2);
        else passes++;
    endtask

    task automatic test_async_reset();
        int lat; logic [31:0] h, l; bit bok, pok;
        set_hilo(32'h76543210, 32'hFEDCBA98);
        @(negedge clk);
        start = 1'b1; funct = F_DIV; opA = 32'd1234567; opB = 32'd89;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'h0)
            $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
        else passes++;
        rst_n = 1'b1;                     // released before the next rising edge
        do_op(F_DIVU, 32'd9, 32'd4, lat, h, l, bok, pok);
        checks++;
        if (lat != 33 || !bok || !pok || h !== 32'd1 || l !== 32'd2)
            $display("FAIL reset_then_divu: lat=%0d busy_ok=%b pulse_ok=%b hi=%h lo=%h, want 33/1/1/1/2", lat, bok, pok, h, l);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mthi_mtlo();
        test_ignored_funct();
        test_cancel_run();
        test_cancel_fix();
        test_cancel_idle();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
